// File: rtl/cc_pkg.sv
//------------------------------------------------------------------------------
// cc_pkg : condition-code bit indices, reset value and pipeline entry record
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cc_pkg;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  localparam logic [3:0] CC_RESET = 4'b0000;

  typedef struct packed {
    logic       valid;
    logic [3:0] flags;
  } flag_entry_t;

endpackage

`default_nettype wire

// File: rtl/flag_gen.sv
//------------------------------------------------------------------------------
// flag_gen : combinational N/Z/C/V generation from the EX-stage ALU result
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flag_gen
  import cc_pkg::*;
(
  input  logic [31:0] i_result,
  input  logic        i_logic_op,
  input  logic        i_alu_c,
  input  logic        i_alu_v,
  input  logic        i_shift_c,
  input  logic        i_base_v,
  output logic [3:0]  o_flags
);

  // Logical ops take carry from the shifter and leave V as it already stands.
  always_comb begin
    o_flags       = CC_RESET;
    o_flags[CC_N] = i_result[31];
    o_flags[CC_Z] = (i_result == 32'd0);
    o_flags[CC_C] = i_logic_op ? i_shift_c : i_alu_c;
    o_flags[CC_V] = i_logic_op ? i_base_v  : i_alu_v;
  end

endmodule

`default_nettype wire

// File: rtl/flag_pipeline.sv
//------------------------------------------------------------------------------
// flag_pipeline : MEM/WB flag latches, WB commit and youngest-first forwarding
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flag_pipeline
  import cc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        EX_valid,
  input  logic        EX_S,
  input  logic        EX_logic,
  input  logic [31:0] ALU_result,
  input  logic        ALU_C,
  input  logic        ALU_V,
  input  logic        Shift_C,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  CC_out,
  output logic [3:0]  CC_commit,
  output logic        flags_pending
);

  flag_entry_t r_mem;
  flag_entry_t r_wb;
  logic [3:0]  r_cc_commit;

  logic [3:0]  w_base;
  logic [3:0]  w_ex_flags;
  logic        w_ex_live;

  // Gating with reset_n keeps CC_out at the reset value while reset is held.
  assign w_ex_live = EX_valid & EX_S & ~flush & reset_n;

  always_comb begin
    w_base = r_cc_commit;
    if (r_mem.valid)
      w_base = r_mem.flags;
    else if (r_wb.valid)
      w_base = r_wb.flags;
  end

  flag_gen u_flag_gen (
    .i_result   (ALU_result),
    .i_logic_op (EX_logic),
    .i_alu_c    (ALU_C),
    .i_alu_v    (ALU_V),
    .i_shift_c  (Shift_C),
    .i_base_v   (w_base[CC_V]),
    .o_flags    (w_ex_flags)
  );

  // Flush beats stall; the WB entry predates the fault and still commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem       <= '0;
      r_wb        <= '0;
      r_cc_commit <= CC_RESET;
    end else if (flush) begin
      r_mem.valid <= 1'b0;
      r_wb.valid  <= 1'b0;
      if (r_wb.valid)
        r_cc_commit <= r_wb.flags;
    end else if (!stall) begin
      r_mem <= {w_ex_live, w_ex_flags};
      r_wb  <= r_mem;
      if (r_wb.valid)
        r_cc_commit <= r_wb.flags;
    end
  end

  assign CC_out        = w_ex_live ? w_ex_flags : w_base;
  assign CC_commit     = r_cc_commit;
  assign flags_pending = r_mem.valid | r_wb.valid;

endmodule

`default_nettype wire

// File: tb/tb_flag_pipeline.sv
//------------------------------------------------------------------------------
// tb_flag_pipeline : directed and randomized checks of flag_pipeline
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_flag_pipeline;

  logic        clk;
  logic        reset_n;
  logic        EX_valid;
  logic        EX_S;
  logic        EX_logic;
  logic [31:0] ALU_result;
  logic        ALU_C;
  logic        ALU_V;
  logic        Shift_C;
  logic        stall;
  logic        flush;
  logic [3:0]  CC_out;
  logic [3:0]  CC_commit;
  logic        flags_pending;

  int checks = 0;
  int errors = 0;

  flag_pipeline dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .EX_valid      (EX_valid),
    .EX_S          (EX_S),
    .EX_logic      (EX_logic),
    .ALU_result    (ALU_result),
    .ALU_C         (ALU_C),
    .ALU_V         (ALU_V),
    .Shift_C       (Shift_C),
    .stall         (stall),
    .flush         (flush),
    .CC_out        (CC_out),
    .CC_commit     (CC_commit),
    .flags_pending (flags_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic lg, input logic [31:0] res,
                       input logic c, input logic ov, input logic sc);
    EX_valid = v; EX_S = s; EX_logic = lg; ALU_result = res;
    ALU_C = c; ALU_V = ov; Shift_C = sc;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      checks++;
      if (CC_out !== 4'b0000 || CC_commit !== 4'b0000 || flags_pending !== 1'b0) begin
        errors++;
        $display("FAIL reset: CC_out=%b CC_commit=%b pending=%b required 0000 0000 0", CC_out, CC_commit, flags_pending);
      end
    end
    stall = 1'b0; flush = 1'b0;
    bubble();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (CC_out !== 4'b0110) begin
      errors++; $display("FAIL arith_cc_same_cycle: got %b required 0110", CC_out);
    end
    tick(); bubble();
    checks++;
    if (flags_pending !== 1'b1 || CC_out !== 4'b0110 || CC_commit !== 4'b0000) begin
      errors++; $display("FAIL arith_in_mem: pending=%b cc=%b commit=%b required 1 0110 0000", flags_pending, CC_out, CC_commit);
    end
    tick();
    checks++;
    if (flags_pending !== 1'b1 || CC_out !== 4'b0110 || CC_commit !== 4'b0000) begin
      errors++; $display("FAIL arith_in_wb: pending=%b cc=%b commit=%b required 1 0110 0000", flags_pending, CC_out, CC_commit);
    end
    tick();
    checks++;
    if (flags_pending !== 1'b0 || CC_commit !== 4'b0110) begin
      errors++; $display("FAIL arith_commit: pending=%b commit=%b required 0 0110", flags_pending, CC_commit);
    end
  endtask

  task automatic test_forward_chain();
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (CC_out !== 4'b1001) begin
      errors++; $display("FAIL fwd_first: got %b required 1001", CC_out);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (CC_out !== 4'b0011) begin
      errors++; $display("FAIL fwd_logic_v_from_mem: got %b required 0011", CC_out);
    end
    tick(); bubble();
    tick();
    checks++;
    if (CC_commit !== 4'b1001 || CC_out !== 4'b0011) begin
      errors++; $display("FAIL fwd_mid: commit=%b cc=%b required 1001 0011", CC_commit, CC_out);
    end
    tick();
    checks++;
    if (CC_commit !== 4'b0011 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL fwd_commit: commit=%b pending=%b required 0011 0", CC_commit, flags_pending);
    end
  endtask

  task automatic test_non_s();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b1, 1'b1);
      else
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'h0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (CC_out !== 4'b0011) begin
        errors++; $display("FAIL non_s_cc: got %b required 0011", CC_out);
      end
      tick();
      checks++;
      if (flags_pending !== 1'b0 || CC_commit !== 4'b0011) begin
        errors++; $display("FAIL non_s_latch: pending=%b commit=%b required 0 0011", flags_pending, CC_commit);
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick(); bubble();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (CC_commit !== 4'b0011 || CC_out !== 4'b1011 || flags_pending !== 1'b1) begin
        errors++; $display("FAIL stall_hold: commit=%b cc=%b pending=%b required 0011 1011 1", CC_commit, CC_out, flags_pending);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (CC_commit !== 4'b0011 || flags_pending !== 1'b1) begin
      errors++; $display("FAIL stall_resume1: commit=%b pending=%b required 0011 1", CC_commit, flags_pending);
    end
    tick();
    checks++;
    if (CC_commit !== 4'b1011 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL stall_resume2: commit=%b pending=%b required 1011 0", CC_commit, flags_pending);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 32'h7, 1'b1, 1'b0, 1'b0);       // A = 0010
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);       // B = 0100, V from A
    checks++;
    if (CC_out !== 4'b0100) begin
      errors++; $display("FAIL flush_b_fwd: got %b required 0100", CC_out);
    end
    tick();
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (CC_out !== 4'b0100) begin
      errors++; $display("FAIL flush_ex_squash: got %b required 0100", CC_out);
    end
    tick();
    flush = 1'b0; stall = 1'b0;
    bubble();
    checks++;
    if (CC_commit !== 4'b0010 || CC_out !== 4'b0010 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL flush_result: commit=%b cc=%b pending=%b required 0010 0010 0", CC_commit, CC_out, flags_pending);
    end
    tick();
    checks++;
    if (CC_commit !== 4'b0010) begin
      errors++; $display("FAIL flush_no_late_commit: got %b required 0010", CC_commit);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (CC_out !== 4'b0000 || CC_commit !== 4'b0000 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL reset_midop: cc=%b commit=%b pending=%b required 0000 0000 0", CC_out, CC_commit, flags_pending);
    end
    bubble();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (CC_commit !== 4'b0000 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL reset_no_partial: commit=%b pending=%b required 0000 0", CC_commit, flags_pending);
    end
  endtask

  // Reference: in-flight entries listed youngest first; CC_out picks the first valid one.
  task automatic test_random();
    logic       pv [2];
    logic [3:0] pf [2];
    logic [3:0] commit, base, ef, exp_cc;
    logic       v, s, lg, c, ov, sc, live;
    logic [31:0] res;
    pv[0] = 1'b0; pv[1] = 1'b0; pf[0] = 4'h0; pf[1] = 4'h0; commit = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v   = ($urandom_range(0, 9) < 8);
      s   = ($urandom_range(0, 9) < 6);
      lg  = 1'($urandom_range(0, 1));
      res = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      c   = 1'($urandom_range(0, 1));
      ov  = 1'($urandom_range(0, 1));
      sc  = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(v, s, lg, res, c, ov, sc);

      base = commit;
      for (int k = 1; k >= 0; k--)
        if (pv[k]) base = pf[k];
      ef = {res[31], res == 32'd0, lg ? sc : c, lg ? base[0] : ov};
      live = v && s && !flush;
      exp_cc = live ? ef : base;
      checks++;
      if (CC_out !== exp_cc) begin
        errors++; $display("FAIL rand_cc cyc %0d: got %b required %b", cyc, CC_out, exp_cc);
      end

      if (flush || !stall) begin
        if (pv[1]) commit = pf[1];
        if (flush) begin
          pv[0] = 1'b0; pv[1] = 1'b0;
        end else begin
          pv[1] = pv[0]; pf[1] = pf[0];
          pv[0] = live;  pf[0] = ef;
        end
      end
      tick();
      checks++;
      if (CC_commit !== commit || flags_pending !== (pv[0] | pv[1])) begin
        errors++; $display("FAIL rand_state cyc %0d: commit=%b pending=%b required %b %b",
                           cyc, CC_commit, flags_pending, commit, pv[0] | pv[1]);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble();
    test_reset();
    test_arith();
    test_forward_chain();
    test_non_s();
    test_stall();
    test_flush();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
